// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word requests to a one-cycle synchronous
// instruction memory and queues returned words with their PCs for decode.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

  logic [31:0]     pc_q;
  logic [31:0]     req_pc_q;
  logic            inflight_q;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [31:0]     code_q [FIFO_DEPTH];
  logic [31:0]     pcs_q  [FIFO_DEPTH];

  logic            not_empty;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CntW:0]   occupancy;

  assign not_empty  = (count_q != '0);
  assign inst_valid = not_empty && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight_q && !redirect_valid;

  // Entries still owed to the FIFO after this cycle's pop; a request only goes out
  // when its response is guaranteed a free slot.
  assign occupancy  = {1'b0, count_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
  assign issue      = reset_n && !redirect_valid && (occupancy < DepthW);

  assign imem_req   = issue;
  assign imem_addr  = pc_q;
  assign inst_code  = not_empty ? code_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = not_empty ? pcs_q[rd_ptr_q]  : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= PC_RESET;
      req_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        code_q[i] <= 32'h0;
        pcs_q[i]  <= 32'h0;
      end
    end else if (redirect_valid) begin
      // Flush queue and drop any response arriving this cycle.
      pc_q       <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
      if (push) begin
        code_q[wr_ptr_q] <= imem_rdata;
        pcs_q[wr_ptr_q]  <= req_pc_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a one-cycle synchronous memory model.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;

  int n_cmp;
  int n_err;

  if_fetch_stage #(
    .PC_RESET  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_code     (inst_code),
    .inst_pc       (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h00B0_0113;
    return a ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  // Advance to the next cycle, apply inputs away from the edge, let outputs settle.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    n_cmp++;
    if ({imem_req, inst_valid, inst_code, inst_pc} !== 66'h0) begin
      $display("FAIL reset_outputs: got req=%b valid=%b code=%h pc=%h, want all 0",
               imem_req, inst_valid, inst_code, inst_pc);
      n_err++;
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8;
    do_reset();
    // Cycle 0 is the first cycle after release; samples happen within the cycle.
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc(1'b1, 1'b0, 32'h0);
      if (c < 3) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr[c]) begin
          $display("FAIL stream_req c%0d: got req=%b addr=%h, want 1 %h",
                   c, imem_req, imem_addr, exp_addr[c]);
          n_err++;
        end
      end
      n_cmp++;
      if (c < 2 && inst_valid !== 1'b0) begin
        $display("FAIL stream_latency c%0d: got valid=%b, want 0", c, inst_valid);
        n_err++;
      end else if (c == 2 && {inst_valid, inst_pc, inst_code} !== {1'b1, 32'h0, 32'h00A0_0093}) begin
        $display("FAIL stream_first: got %b %h %h, want 1 0 00a00093",
                 inst_valid, inst_pc, inst_code);
        n_err++;
      end else if (c == 3 && {inst_valid, inst_pc, inst_code} !== {1'b1, 32'h4, 32'h00B0_0113}) begin
        $display("FAIL stream_second: got %b %h %h, want 1 4 00b00113",
                 inst_valid, inst_pc, inst_code);
        n_err++;
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    inst_ready = 1'b0;
    #1;
    // c0,c1 issue 0x0,0x4; c2..c5 FIFO full or filling, no request, head held.
    for (int c = 1; c <= 5; c++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (c >= 2) begin
        n_cmp++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0 ||
            inst_code !== 32'h00A0_0093) begin
          $display("FAIL stall_hold c%0d: got req=%b valid=%b pc=%h code=%h, want 0 1 0 00a00093",
                   c, imem_req, inst_valid, inst_pc, inst_code);
          n_err++;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_code !== mem_word(32'(4 * k))) begin
        $display("FAIL stall_resume k%0d: got valid=%b pc=%h code=%h, want 1 %h %h",
                 k, inst_valid, inst_pc, inst_code, 32'(4 * k), mem_word(32'(4 * k)));
        n_err++;
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    #1;
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    // c3: 0x4 at head, 0x8 response arriving; redirect flushes both.
    cyc(1'b1, 1'b1, 32'h0000_0100);
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      $display("FAIL redir_cycle: got valid=%b req=%b, want 0 0", inst_valid, imem_req);
      n_err++;
    end
    cyc(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      $display("FAIL redir_fetch: got req=%b addr=%h valid=%b, want 1 00000100 0",
               imem_req, imem_addr, inst_valid);
      n_err++;
    end
    cyc(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      $display("FAIL redir_flushed: got valid=%b pc=%h, want 0", inst_valid, inst_pc);
      n_err++;
    end
    cyc(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_code !== mem_word(32'h100)) begin
      $display("FAIL redir_deliver: got valid=%b pc=%h code=%h, want 1 00000100 %h",
               inst_valid, inst_pc, inst_code, mem_word(32'h100));
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b1, 32'h0000_0200);
    cyc(1'b1, 1'b1, 32'h0000_0102);
    cyc(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      $display("FAIL b2b_align: got req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
      n_err++;
    end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_top: got req=%b addr=%h, want 1 fffffffc", imem_req, imem_addr);
      n_err++;
    end
    cyc(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      $display("FAIL wrap_zero: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
      n_err++;
    end
    cyc(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_deliver: got valid=%b pc=%h, want 1 fffffffc", inst_valid, inst_pc);
      n_err++;
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    inst_ready = 1'b0;
    #1;
    for (int c = 1; c <= 3; c++) cyc(1'b0, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req, inst_valid, inst_code, inst_pc} !== 66'h0) begin
      $display("FAIL midreset_async: got req=%b valid=%b code=%h pc=%h, want all 0",
               imem_req, inst_valid, inst_code, inst_pc);
      n_err++;
    end
    @(negedge clk);
    @(negedge clk);
    reset_n    = 1'b1;
    inst_ready = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      $display("FAIL midreset_restart: got req=%b addr=%h valid=%b, want 1 0 0",
               imem_req, imem_addr, inst_valid);
      n_err++;
    end
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_code !== 32'h00A0_0093) begin
      $display("FAIL midreset_first: got valid=%b pc=%h code=%h, want 1 0 00a00093",
               inst_valid, inst_pc, inst_code);
      n_err++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
